operand_b_stage: RTL and testbench
==================================

Name: operand_b_stage

Overview:
- Upstream feeder for the datapath shifter: holds the 8-entry x 16-bit general register file and the B operand pipeline register.
- Captures the register selected by readnum, together with the 2-bit shift code, into a registered B slot.
- Presents the slot to the shifter with a valid/ready handshake, so the shifter/ALU side can stall the stage.

Parameters:
- DATA_W, 16, width of every register and of the B operand.
- REG_CNT, 8, number of general registers; index width is log2(REG_CNT) = 3.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- reset_n  input  1  reset, synchronous and active-low.
- write  input  1  register-file write enable.
- writenum  input  3  register-file write index.
- data_in  input  16  register-file write data.
- readnum  input  3  register-file read index for the B load.
- loadb  input  1  request to capture register[readnum] into the B slot.
- shift_in  input  2  shift code captured alongside the operand.
- load_ack  output  1  combinational; high when loadb is accepted this cycle.
- b_out  output  16  registered B operand; drives the shifter data input.
- shift_out  output  2  registered shift code; drives the shifter shift input.
- b_valid  output  1  B slot holds an unconsumed operand.
- b_ready  input  1  consumer takes the B slot this cycle.

Behaviour:
- Reset (clk edge with reset_n = 0):
  - All registers R0..R7 = 0; b_out = 0; shift_out = 2'b00; b_valid = 0.
  - Reset overrides any write or loadb in the same cycle, including a reset arriving mid-transfer.
- Register write: on a clk edge with write = 1, R[writenum] <= data_in. Writes proceed regardless of handshake state.
- Slot state machine, two states:
  - EMPTY (b_valid = 0).
  - FULL (b_valid = 1).
- Accept rule:
  - load_ack = loadb & (~b_valid | b_ready).
  - On accept, at the next edge: b_out <= R[readnum], shift_out <= shift_in, b_valid <= 1.
- Transitions:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on b_ready with no loadb.
  - FULL stays FULL on b_ready with loadb (back-to-back load, one operand per cycle).
  - FULL with b_ready = 0 stays FULL: b_out and shift_out hold, and loadb is refused (load_ack = 0; requester must hold its request).
- b_ready while EMPTY is ignored.
- Latency: one cycle from accepted loadb to b_out/b_valid.
- Read-during-write, same index, same cycle: without forwarding, the B slot captures the old register value; the register takes the new value.
- Index decode: every value 0..7 is legal; no out-of-range case exists at REG_CNT = 8.
- Outputs b_out, shift_out and b_valid come directly from flops, with no combinational path from inputs. load_ack is the only combinational output.

Optional Feature:
- Macro: OPB_WRITE_FWD_EN.
- Defined: when write & loadb & (writenum == readnum) and the load is accepted, b_out captures data_in instead of the stale register value.
- Undefined: old-value semantics exactly as stated in Behaviour.
- Register-file contents are identical in both builds.

Decomposition:
- Shared package opb_pkg holds:
  - DATA_W and REG_CNT.
  - Index width constant IDX_W = 3.
  - Shift-code constants SH_NONE = 2'b00, SH_LSL = 2'b01, SH_LSR = 2'b10, SH_ASR = 2'b11.
- The shifter reuses the shift-code constants from opb_pkg.
- One natural sub-module: regfile8, containing the 8x16 storage, write decode and read mux. operand_b_stage wraps it with the slot FSM and the forwarding mux.

Test Plan:
- Reset then idle: hold reset_n = 0 for 2 cycles with write = 1 and loadb = 1 -> after release, b_valid = 0, b_out = 16'h0000, shift_out = 2'b00, and a load from R5 returns 16'h0000.
- Write and load: write R3 = 16'hF0CF; next cycle loadb with readnum = 3, shift_in = 2'b11 -> one cycle later b_out = 16'hF0CF, shift_out = 2'b11, b_valid = 1.
- Stall: slot FULL with R3 value and b_ready = 0; assert loadb with readnum = 5 (R5 = 16'h1234) for 3 cycles -> load_ack = 0 throughout and b_out holds 16'hF0CF. Raise b_ready -> load_ack = 1 and b_out = 16'h1234 the next cycle.
- Back-to-back: b_ready = 1 constantly; loads of R0..R7 (R[i] = 16'h1111*i) on consecutive cycles -> b_out follows 16'h0000 .. 16'h7777 one per cycle, with b_valid continuously 1.
- Read-during-write: R2 = 16'hAAAA; in the same cycle, write R2 = 16'h5555 and loadb readnum = 2 -> b_out = 16'hAAAA without OPB_WRITE_FWD_EN, 16'h5555 with it; R2 = 16'h5555 afterwards in both builds.
- Mid-operation reset: slot FULL with 16'hF0CF and b_ready = 0; pulse reset_n = 0 for one cycle -> b_valid = 0, b_out = 0, and all registers read 0.

Source files
------------

// File: rtl/opb_pkg.sv
// ---------------------------------------------------------------------------
// opb_pkg: constants shared by the B-operand stage and the downstream shifter.
//   DATA_W  : width of each general register and of the B operand
//   REG_CNT : number of general registers
//   IDX_W   : register index width
//   SH_*    : 2-bit shift codes carried alongside the operand
//   slot_state_t : B-slot state encoding
// ---------------------------------------------------------------------------
package opb_pkg;
   localparam int DATA_W  = 16;
   localparam int REG_CNT = 8;
   localparam int IDX_W   = 3;

   localparam logic [1:0] SH_NONE = 2'b00;
   localparam logic [1:0] SH_LSL  = 2'b01;
   localparam logic [1:0] SH_LSR  = 2'b10;
   localparam logic [1:0] SH_ASR  = 2'b11;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } slot_state_t;
endpackage

// File: rtl/regfile8.sv
// ---------------------------------------------------------------------------
// regfile8: 8 x 16-bit general register file, one write port, one
// combinational read port.
//   i_clk      : rising-edge clock
//   i_reset_n  : synchronous active-low reset, clears every register
//   i_we       : write enable
//   i_wr_idx   : write index
//   i_wr_data  : write data
//   i_rd_idx   : read index
//   o_rd_data  : current contents of register[i_rd_idx] (old value during a
//                same-cycle write)
// ---------------------------------------------------------------------------
module regfile8
   import opb_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_we,
   input  logic [IDX_W-1:0]  i_wr_idx,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic [IDX_W-1:0]  i_rd_idx,
   output logic [DATA_W-1:0] o_rd_data
);

   logic [DATA_W-1:0] r_mem [REG_CNT];

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         for (int i = 0; i < REG_CNT; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we) begin
         r_mem[i_wr_idx] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/operand_b_stage.sv
// ---------------------------------------------------------------------------
// operand_b_stage: register file plus the registered B operand slot that
// feeds the shifter, with a valid/ready handshake toward the consumer.
//
// Optional build macro: OPB_WRITE_FWD_EN
//   defined   - a load that reads the register being written in the same
//               cycle captures data_in (the new value)
//   undefined - such a load captures the old register value
//
// Ports:
//   clk, reset_n          : clock, synchronous active-low reset
//   write/writenum/data_in: register-file write port
//   readnum, loadb        : load request for register[readnum]
//   shift_in              : shift code captured with the operand
//   load_ack              : combinational, load accepted this cycle
//   b_out, shift_out      : registered operand and shift code
//   b_valid               : slot holds an unconsumed operand
//   b_ready               : consumer takes the slot this cycle
//
// Slot states:
//   state    | meaning
//   ST_EMPTY | no operand held, b_valid = 0, any loadb is accepted
//   ST_FULL  | operand held, b_valid = 1, loadb accepted only with b_ready
// ---------------------------------------------------------------------------
module operand_b_stage
   import opb_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              write,
   input  logic [IDX_W-1:0]  writenum,
   input  logic [DATA_W-1:0] data_in,
   input  logic [IDX_W-1:0]  readnum,
   input  logic              loadb,
   input  logic [1:0]        shift_in,
   output logic              load_ack,
   output logic [DATA_W-1:0] b_out,
   output logic [1:0]        shift_out,
   output logic              b_valid,
   input  logic              b_ready
);

   slot_state_t       r_state;
   logic [DATA_W-1:0] r_b;
   logic [1:0]        r_shift;
   logic              r_valid;

   logic [DATA_W-1:0] w_rd_data;
   logic [DATA_W-1:0] w_b_next;
   logic              w_load_ack;

   regfile8 u_regfile (
      .i_clk     (clk),
      .i_reset_n (reset_n),
      .i_we      (write),
      .i_wr_idx  (writenum),
      .i_wr_data (data_in),
      .i_rd_idx  (readnum),
      .o_rd_data (w_rd_data)
   );

`ifdef OPB_WRITE_FWD_EN
   assign w_b_next = (write && (writenum == readnum)) ? data_in : w_rd_data;
`else
   assign w_b_next = w_rd_data;
`endif

   // A full slot can only take a new operand when the current one leaves.
   assign w_load_ack = loadb & ((r_state == ST_EMPTY) | b_ready);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= ST_EMPTY;
         r_b     <= '0;
         r_shift <= SH_NONE;
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_load_ack) begin
                  r_b     <= w_b_next;
                  r_shift <= shift_in;
                  r_valid <= 1'b1;
                  r_state <= ST_FULL;
               end
            end
            ST_FULL: begin
               if (w_load_ack) begin
                  r_b     <= w_b_next;
                  r_shift <= shift_in;
                  r_valid <= 1'b1;
               end else if (b_ready) begin
                  r_valid <= 1'b0;
                  r_state <= ST_EMPTY;
               end
            end
            default: begin
               r_valid <= 1'b0;
               r_state <= ST_EMPTY;
            end
         endcase
      end
   end

   assign load_ack  = w_load_ack;
   assign b_out     = r_b;
   assign shift_out = r_shift;
   assign b_valid   = r_valid;

endmodule

// File: tb/tb_operand_b_stage.sv
module tb_operand_b_stage;
   import opb_pkg::*;

   typedef struct packed {
      logic [DATA_W-1:0] d;
      logic [1:0]        s;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              write;
   logic [IDX_W-1:0]  writenum;
   logic [DATA_W-1:0] data_in;
   logic [IDX_W-1:0]  readnum;
   logic              loadb;
   logic [1:0]        shift_in;
   logic              load_ack;
   logic [DATA_W-1:0] b_out;
   logic [1:0]        shift_out;
   logic              b_valid;
   logic              b_ready;

   int ntests = 0;
   int nfail  = 0;

   logic [DATA_W-1:0] m_regs [REG_CNT];
   logic              m_valid;
   exp_t              sb [$];
   exp_t              e;

   always #5 clk = ~clk;

   operand_b_stage dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .write     (write),
      .writenum  (writenum),
      .data_in   (data_in),
      .readnum   (readnum),
      .loadb     (loadb),
      .shift_in  (shift_in),
      .load_ack  (load_ack),
      .b_out     (b_out),
      .shift_out (shift_out),
      .b_valid   (b_valid),
      .b_ready   (b_ready)
   );

   function automatic logic model_ack();
      return loadb & (~m_valid | b_ready);
   endfunction

   // Advance the reference model and scoreboard by one edge using the
   // inputs currently driven, then return at the following negedge.
   task automatic tick();
      exp_t x;
      if (!reset_n) begin
         for (int i = 0; i < REG_CNT; i++) m_regs[i] = '0;
         m_valid = 1'b0;
         sb.delete();
      end else begin
         if (model_ack()) begin
`ifdef OPB_WRITE_FWD_EN
            x.d = (write && writenum == readnum) ? data_in : m_regs[readnum];
`else
            x.d = m_regs[readnum];
`endif
            x.s = shift_in;
            sb.push_back(x);
            m_valid = 1'b1;
         end else if (m_valid && b_ready) begin
            m_valid = 1'b0;
         end
         if (write) m_regs[writenum] = data_in;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      write = 0; writenum = 0; data_in = 0; readnum = 0;
      loadb = 0; shift_in = SH_NONE; b_ready = 0;
   endtask

   task automatic test_reset();
      reset_n = 0; write = 1; writenum = 5; data_in = 16'hFFFF;
      loadb = 1; readnum = 5; shift_in = SH_ASR; b_ready = 0;
      tick(); tick();
      reset_n = 1;
      idle_inputs();
      #1;
      ntests++;
      if (b_valid !== 1'b0) begin nfail++; $display("FAIL reset_valid got=%0b exp=0", b_valid); end
      ntests++;
      if (b_out !== 16'h0000) begin nfail++; $display("FAIL reset_b_out got=%h exp=0000", b_out); end
      ntests++;
      if (shift_out !== 2'b00) begin nfail++; $display("FAIL reset_shift got=%b exp=00", shift_out); end
      loadb = 1; readnum = 5; b_ready = 1; #1;
      ntests++;
      if (load_ack !== 1'b1) begin nfail++; $display("FAIL reset_load_ack got=%0b exp=1", load_ack); end
      tick();
      ntests++;
      if (sb.size() != 1) begin nfail++; $display("FAIL reset_sb_size got=%0d exp=1", sb.size()); end
      else begin
         e = sb.pop_front();
         if (b_out !== e.d || e.d !== 16'h0000 || b_valid !== 1'b1) begin
            nfail++; $display("FAIL reset_load_r5 got=%h/%0b exp=%h/1", b_out, b_valid, e.d);
         end
      end
   endtask

   task automatic test_write_load();
      idle_inputs();
      b_ready = 1; write = 1; writenum = 3; data_in = 16'hF0CF;
      tick();
      ntests++;
      if (b_valid !== m_valid) begin nfail++; $display("FAIL wl_drain got=%0b exp=%0b", b_valid, m_valid); end
      idle_inputs();
      loadb = 1; readnum = 3; shift_in = SH_ASR; #1;
      ntests++;
      if (load_ack !== 1'b1) begin nfail++; $display("FAIL wl_ack got=%0b exp=1", load_ack); end
      tick();
      ntests++;
      if (sb.size() != 1) begin nfail++; $display("FAIL wl_sb_size got=%0d exp=1", sb.size()); end
      else begin
         e = sb.pop_front();
         if (b_out !== e.d || shift_out !== e.s || b_valid !== 1'b1 || e.d !== 16'hF0CF) begin
            nfail++; $display("FAIL wl_out got=%h/%b/%0b exp=%h/%b/1", b_out, shift_out, b_valid, e.d, e.s);
         end
      end
   endtask

   task automatic test_stall();
      idle_inputs();
      write = 1; writenum = 5; data_in = 16'h1234;
      tick();
      idle_inputs();
      loadb = 1; readnum = 5; shift_in = SH_LSL; b_ready = 0;
      for (int c = 0; c < 3; c++) begin
         #1;
         ntests++;
         if (load_ack !== 1'b0) begin nfail++; $display("FAIL stall_ack cyc=%0d got=%0b exp=0", c, load_ack); end
         tick();
         ntests++;
         if (b_out !== 16'hF0CF || shift_out !== SH_ASR || b_valid !== 1'b1 || sb.size() != 0) begin
            nfail++; $display("FAIL stall_hold cyc=%0d got=%h/%b/%0b exp=f0cf/11/1", c, b_out, shift_out, b_valid);
         end
      end
      b_ready = 1; #1;
      ntests++;
      if (load_ack !== 1'b1) begin nfail++; $display("FAIL stall_release_ack got=%0b exp=1", load_ack); end
      tick();
      ntests++;
      if (sb.size() != 1) begin nfail++; $display("FAIL stall_sb_size got=%0d exp=1", sb.size()); end
      else begin
         e = sb.pop_front();
         if (b_out !== e.d || shift_out !== e.s || e.d !== 16'h1234) begin
            nfail++; $display("FAIL stall_release got=%h/%b exp=%h/%b", b_out, shift_out, e.d, e.s);
         end
      end
      loadb = 0; b_ready = 1;
      tick();
      ntests++;
      if (b_valid !== 1'b0) begin nfail++; $display("FAIL stall_drain got=%0b exp=0", b_valid); end
   endtask

   task automatic test_back_to_back();
      logic [DATA_W-1:0] v;
      idle_inputs();
      for (int i = 0; i < REG_CNT; i++) begin
         write = 1; writenum = i[IDX_W-1:0]; v = 16'h1111 * i[DATA_W-1:0]; data_in = v;
         tick();
      end
      idle_inputs();
      b_ready = 1;
      for (int i = 0; i < REG_CNT; i++) begin
         loadb = 1; readnum = i[IDX_W-1:0]; shift_in = i[1:0]; #1;
         ntests++;
         if (load_ack !== 1'b1) begin nfail++; $display("FAIL b2b_ack i=%0d got=%0b exp=1", i, load_ack); end
         tick();
         ntests++;
         if (sb.size() != 1) begin nfail++; $display("FAIL b2b_sb_size i=%0d got=%0d exp=1", i, sb.size()); end
         else begin
            e = sb.pop_front();
            v = 16'h1111 * i[DATA_W-1:0];
            if (b_out !== e.d || shift_out !== e.s || b_valid !== 1'b1 || e.d !== v) begin
               nfail++; $display("FAIL b2b_out i=%0d got=%h/%b/%0b exp=%h/%b/1", i, b_out, shift_out, b_valid, e.d, e.s);
            end
         end
      end
      loadb = 0;
      tick();
      ntests++;
      if (b_valid !== 1'b0) begin nfail++; $display("FAIL b2b_drain got=%0b exp=0", b_valid); end
   endtask

   task automatic test_read_during_write();
      logic [DATA_W-1:0] want;
      idle_inputs();
      write = 1; writenum = 2; data_in = 16'hAAAA;
      tick();
      write = 1; writenum = 2; data_in = 16'h5555;
      loadb = 1; readnum = 2; shift_in = SH_LSR; b_ready = 1;
`ifdef OPB_WRITE_FWD_EN
      want = 16'h5555;
`else
      want = 16'hAAAA;
`endif
      tick();
      ntests++;
      if (sb.size() != 1) begin nfail++; $display("FAIL rdw_sb_size got=%0d exp=1", sb.size()); end
      else begin
         e = sb.pop_front();
         if (b_out !== e.d || e.d !== want) begin
            nfail++; $display("FAIL rdw_capture got=%h exp=%h", b_out, want);
         end
      end
      write = 0;
      tick();
      ntests++;
      if (sb.size() != 1) begin nfail++; $display("FAIL rdw_after_sb_size got=%0d exp=1", sb.size()); end
      else begin
         e = sb.pop_front();
         if (b_out !== e.d || e.d !== 16'h5555) begin
            nfail++; $display("FAIL rdw_after got=%h exp=5555", b_out);
         end
      end
      loadb = 0;
      tick();
   endtask

   task automatic test_mid_reset();
      idle_inputs();
      write = 1; writenum = 3; data_in = 16'hF0CF;
      tick();
      idle_inputs();
      loadb = 1; readnum = 3; shift_in = SH_ASR;
      tick();
      loadb = 0;
      if (sb.size() != 0) e = sb.pop_front();
      ntests++;
      if (b_out !== 16'hF0CF || b_valid !== 1'b1) begin
         nfail++; $display("FAIL mid_pre got=%h/%0b exp=f0cf/1", b_out, b_valid);
      end
      reset_n = 0; loadb = 1; write = 1; writenum = 1; data_in = 16'hBEEF;
      tick();
      reset_n = 1;
      idle_inputs();
      #1;
      ntests++;
      if (b_valid !== 1'b0 || b_out !== 16'h0000 || shift_out !== 2'b00) begin
         nfail++; $display("FAIL mid_reset got=%h/%b/%0b exp=0000/00/0", b_out, shift_out, b_valid);
      end
      b_ready = 1;
      for (int i = 0; i < REG_CNT; i++) begin
         loadb = 1; readnum = i[IDX_W-1:0];
         tick();
         ntests++;
         if (sb.size() != 1) begin nfail++; $display("FAIL mid_sb_size i=%0d got=%0d exp=1", i, sb.size()); end
         else begin
            e = sb.pop_front();
            if (b_out !== e.d || e.d !== 16'h0000) begin
               nfail++; $display("FAIL mid_reg_clear i=%0d got=%h exp=0000", i, b_out);
            end
         end
      end
      loadb = 0;
      tick();
   endtask

   initial begin
      for (int i = 0; i < REG_CNT; i++) m_regs[i] = '0;
      m_valid = 1'b0;
      idle_inputs();
      reset_n = 0;
      @(negedge clk);
      test_reset();
      test_write_load();
      test_stall();
      test_back_to_back();
      test_read_during_write();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
